// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared definitions for the control pipeline: opcode values,
//                ALU operation encodings and the decoded control bundle types.
//  Macros      : CTRL_SIGNED_CMP_EN (consumed by ctrl_decode)
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Opcodes (instruction[OPW:1] of a run-type word)
    localparam logic [4:0] c_op_li   = 5'b00000;
    localparam logic [4:0] c_op_ld   = 5'b00001;
    localparam logic [4:0] c_op_st   = 5'b00010;
    localparam logic [4:0] c_op_add  = 5'b00011;
    localparam logic [4:0] c_op_sub  = 5'b00100;
    localparam logic [4:0] c_op_xor  = 5'b00101;
    localparam logic [4:0] c_op_or   = 5'b00110;
    localparam logic [4:0] c_op_and  = 5'b00111;
    localparam logic [4:0] c_op_jmp  = 5'b01000;
    localparam logic [4:0] c_op_beq  = 5'b01001;
    localparam logic [4:0] c_op_blt  = 5'b01010;
    localparam logic [4:0] c_op_bgt  = 5'b01011;
    localparam logic [4:0] c_op_shl  = 5'b01100;
    localparam logic [4:0] c_op_shr  = 5'b01101;
    localparam logic [4:0] c_op_usub = 5'b01110;
    localparam logic [4:0] c_op_slt  = 5'b01111;
    localparam logic [4:0] c_op_sgt  = 5'b10000;

    // ALU operation encodings
    localparam logic [3:0] c_alu_and  = 4'b0000;
    localparam logic [3:0] c_alu_xor  = 4'b0001;
    localparam logic [3:0] c_alu_or   = 4'b0010;
    localparam logic [3:0] c_alu_shl  = 4'b0011;
    localparam logic [3:0] c_alu_shr  = 4'b0100;
    localparam logic [3:0] c_alu_add  = 4'b0101;
    localparam logic [3:0] c_alu_sub  = 4'b0110;
    localparam logic [3:0] c_alu_blt  = 4'b0111;
    localparam logic [3:0] c_alu_bgt  = 4'b1000;
    localparam logic [3:0] c_alu_beq  = 4'b1001;
    localparam logic [3:0] c_alu_usub = 4'b1010;
    localparam logic [3:0] c_alu_slt  = 4'b1011;
    localparam logic [3:0] c_alu_sgt  = 4'b1100;
    localparam logic [3:0] c_alu_none = 4'b1111;

    // Everything that travels down the pipe with a bundle
    typedef struct packed {
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       put_en;
        logic       op_en;
        logic       imm_to_reg;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_flags_t;

    // Decoder result: the flags plus the HALT marker, which only steers the
    // FSM at accept time and is therefore not stored with the bundle.
    typedef struct packed {
        ctrl_flags_t flags;
        logic        is_halt;
    } ctrl_bundle_t;

    localparam ctrl_flags_t c_flags_reset = '{
        branch:     1'b0,
        mem_to_reg: 1'b0,
        mem_write:  1'b0,
        reg_write:  1'b0,
        put_en:     1'b0,
        op_en:      1'b0,
        imm_to_reg: 1'b0,
        alu_op:     c_alu_none,
        illegal:    1'b0
    };

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_decode
//  Description : Purely combinational instruction decoder producing a
//                ctrl_bundle_t from the low OPW+1 instruction bits.
//  Ports       : insn   in  [OPW:0] bit 0 = put/run type, [OPW:1] = opcode
//                bundle out         decoded control flags + HALT marker
//  Macros      : CTRL_SIGNED_CMP_EN - enables SLT/SGT; otherwise illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW:0]  insn,
    output ctrl_bundle_t  bundle
);

    logic [OPW-1:0] w_op;
    assign w_op = insn[OPW:1];

    always_comb begin
        bundle                 = '0;
        bundle.flags.alu_op    = c_alu_none;
        bundle.flags.reg_write = 1'b1;
        bundle.flags.op_en     = 1'b1;

        if (insn[0]) begin
            bundle.flags.put_en    = 1'b1;
            bundle.flags.op_en     = 1'b0;
            bundle.flags.reg_write = 1'b0;
        end else begin
            case (w_op)
                OPW'(c_op_li):   bundle.flags.imm_to_reg = 1'b1;
                OPW'(c_op_ld):   bundle.flags.mem_to_reg = 1'b1;
                OPW'(c_op_st): begin
                    bundle.flags.mem_write = 1'b1;
                    bundle.flags.reg_write = 1'b0;
                end
                OPW'(c_op_add):  bundle.flags.alu_op = c_alu_add;
                OPW'(c_op_sub):  bundle.flags.alu_op = c_alu_sub;
                OPW'(c_op_xor):  bundle.flags.alu_op = c_alu_xor;
                OPW'(c_op_or):   bundle.flags.alu_op = c_alu_or;
                OPW'(c_op_and):  bundle.flags.alu_op = c_alu_and;
                OPW'(c_op_shl):  bundle.flags.alu_op = c_alu_shl;
                OPW'(c_op_shr):  bundle.flags.alu_op = c_alu_shr;
                OPW'(c_op_usub): bundle.flags.alu_op = c_alu_usub;
                OPW'(c_op_jmp): begin
                    bundle.flags.branch    = 1'b1;
                    bundle.flags.reg_write = 1'b0;
                end
                OPW'(c_op_beq): begin
                    bundle.flags.alu_op    = c_alu_beq;
                    bundle.flags.reg_write = 1'b0;
                end
                OPW'(c_op_blt): begin
                    bundle.flags.alu_op    = c_alu_blt;
                    bundle.flags.reg_write = 1'b0;
                end
                OPW'(c_op_bgt): begin
                    bundle.flags.alu_op    = c_alu_bgt;
                    bundle.flags.reg_write = 1'b0;
                end
`ifdef CTRL_SIGNED_CMP_EN
                OPW'(c_op_slt): begin
                    bundle.flags.alu_op    = c_alu_slt;
                    bundle.flags.reg_write = 1'b0;
                end
                OPW'(c_op_sgt): begin
                    bundle.flags.alu_op    = c_alu_sgt;
                    bundle.flags.reg_write = 1'b0;
                end
`endif
                default: begin
                    bundle.flags.reg_write = 1'b0;
                    bundle.flags.op_en     = 1'b0;
                    if (&w_op) begin
                        bundle.is_halt = 1'b1;
                    end else begin
                        bundle.flags.illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : control_pipe
//  Description : Registered, valid/ready flow-controlled control decoder with
//                a one-entry skid buffer, duplicate-counter filtering, a HALT
//                state with resume, and a transferred-bundle counter.
//  Ports       : clk, reset (async, active high)
//                instruction/instr_ctr/in_valid -> in_ready   input side
//                out_valid/out_ready, flag outputs, alu_op, value,
//                control_ctr, illegal                          output bundle
//                resume (pulse), halted, decoded_count         status
//  Macros      : CTRL_SIGNED_CMP_EN - decode SLT/SGT instead of illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module control_pipe
    import ctrl_pkg::*;
#(
    parameter int IW  = 9,
    parameter int OPW = 5,
    parameter int PCW = 12
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [IW-1:0]  instruction,
    input  logic [PCW-1:0] instr_ctr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           out_ready,
    input  logic           resume,
    output logic           out_valid,
    output logic           branch_flag,
    output logic           mem_to_reg_flag,
    output logic           mem_write_flag,
    output logic           reg_write_flag,
    output logic           put_en,
    output logic           op_en,
    output logic           imm_to_reg_flag,
    output logic [3:0]     alu_op,
    output logic [IW-2:0]  value,
    output logic [PCW-1:0] control_ctr,
    output logic           illegal,
    output logic           halted,
    output logic [PCW-1:0] decoded_count
);

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_halt = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;

    ctrl_bundle_t   w_dec;

    ctrl_flags_t    r_out_flags;
    logic [IW-2:0]  r_out_value;
    logic [PCW-1:0] r_out_ctr;
    logic           r_out_valid;

    ctrl_flags_t    r_skid_flags;
    logic [IW-2:0]  r_skid_value;
    logic [PCW-1:0] r_skid_ctr;
    logic           r_skid_full;

    logic [PCW-1:0] r_last_ctr;
    logic           r_last_valid;
    logic [PCW-1:0] r_count;
    logic           r_in_ready;

    logic           w_accept;
    logic           w_dup;
    logic           w_load;
    logic           w_xfer;
    logic           w_out_free;
    logic           w_skid_full_nxt;
    logic           w_in_ready_nxt;
    logic           w_resume_exit;
    logic           w_halted;

    ctrl_decode #(
        .OPW    (OPW)
    ) u_decode (
        .insn   (instruction[OPW:0]),
        .bundle (w_dec)
    );

    assign w_accept   = in_valid && r_in_ready;
    assign w_dup      = r_last_valid && (instr_ctr == r_last_ctr);
    assign w_load     = w_accept && !w_dup;
    assign w_xfer     = r_out_valid && out_ready;
    // Output register can take a new entry when it is empty or being drained
    assign w_out_free = !r_out_valid || out_ready;

    // in_ready is low whenever the skid is full, so a load never coincides
    // with a skid-to-output move.
    always_comb begin
        w_skid_full_nxt = r_skid_full;
        if (w_out_free) begin
            w_skid_full_nxt = 1'b0;
        end else if (w_load) begin
            w_skid_full_nxt = 1'b1;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run:  if (w_load && w_dec.is_halt) w_state_nxt = c_st_halt;
            c_st_halt: if (resume)                  w_state_nxt = c_st_run;
            default:   w_state_nxt = c_st_run;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_halted       = (r_state == c_st_halt);
        w_resume_exit  = (r_state == c_st_halt) && resume;
        w_in_ready_nxt = (w_state_nxt == c_st_run) && !w_skid_full_nxt;
    end

    // ---------------- Output / skid registers and counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_flags  <= c_flags_reset;
            r_out_value  <= '0;
            r_out_ctr    <= '0;
            r_skid_full  <= 1'b0;
            r_skid_flags <= c_flags_reset;
            r_skid_value <= '0;
            r_skid_ctr   <= '0;
            r_last_ctr   <= '0;
            r_last_valid <= 1'b0;
            r_count      <= '0;
            r_in_ready   <= 1'b1;
        end else begin
            if (w_out_free) begin
                if (r_skid_full) begin
                    r_out_valid <= 1'b1;
                    r_out_flags <= r_skid_flags;
                    r_out_value <= r_skid_value;
                    r_out_ctr   <= r_skid_ctr;
                end else if (w_load) begin
                    r_out_valid <= 1'b1;
                    r_out_flags <= w_dec.flags;
                    r_out_value <= instruction[IW-1:1];
                    r_out_ctr   <= instr_ctr;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_load) begin
                r_skid_flags <= w_dec.flags;
                r_skid_value <= instruction[IW-1:1];
                r_skid_ctr   <= instr_ctr;
            end
            r_skid_full <= w_skid_full_nxt;

            if (w_load) begin
                r_last_ctr   <= instr_ctr;
                r_last_valid <= 1'b1;
            end else if (w_resume_exit) begin
                // Forget the last counter so the instruction after HALT
                // (typically the same counter) is decoded again.
                r_last_valid <= 1'b0;
            end

            if (w_xfer) begin
                r_count <= r_count + PCW'(1);
            end

            r_in_ready <= w_in_ready_nxt;
        end
    end

    assign in_ready        = r_in_ready;
    assign out_valid       = r_out_valid;
    assign branch_flag     = r_out_flags.branch;
    assign mem_to_reg_flag = r_out_flags.mem_to_reg;
    assign mem_write_flag  = r_out_flags.mem_write;
    assign reg_write_flag  = r_out_flags.reg_write;
    assign put_en          = r_out_flags.put_en;
    assign op_en           = r_out_flags.op_en;
    assign imm_to_reg_flag = r_out_flags.imm_to_reg;
    assign alu_op          = r_out_flags.alu_op;
    assign illegal         = r_out_flags.illegal;
    assign value           = r_out_value;
    assign control_ctr     = r_out_ctr;
    assign halted          = w_halted;
    assign decoded_count   = r_count;

endmodule : control_pipe
`default_nettype wire

// File: tb/tb_control_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_pipe
//  Description : Self-checking bench for control_pipe. A queue-based model
//                tracks the bundles held in the pipe; directed steps followed
//                by randomized traffic are compared against it.
//  Macros      : CTRL_SIGNED_CMP_EN (selects expected SLT/SGT decode)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_pipe;

    logic        clk;
    logic        reset;
    logic [8:0]  instruction;
    logic [11:0] instr_ctr;
    logic        in_valid;
    logic        in_ready;
    logic        out_ready;
    logic        resume;
    logic        out_valid;
    logic        branch_flag, mem_to_reg_flag, mem_write_flag, reg_write_flag;
    logic        put_en, op_en, imm_to_reg_flag;
    logic [3:0]  alu_op;
    logic [7:0]  value;
    logic [11:0] control_ctr;
    logic        illegal;
    logic        halted;
    logic [11:0] decoded_count;

    control_pipe #(.IW(9), .OPW(5), .PCW(12)) dut (
        .clk             (clk),
        .reset           (reset),
        .instruction     (instruction),
        .instr_ctr       (instr_ctr),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_ready       (out_ready),
        .resume          (resume),
        .out_valid       (out_valid),
        .branch_flag     (branch_flag),
        .mem_to_reg_flag (mem_to_reg_flag),
        .mem_write_flag  (mem_write_flag),
        .reg_write_flag  (reg_write_flag),
        .put_en          (put_en),
        .op_en           (op_en),
        .imm_to_reg_flag (imm_to_reg_flag),
        .alu_op          (alu_op),
        .value           (value),
        .control_ctr     (control_ctr),
        .illegal         (illegal),
        .halted          (halted),
        .decoded_count   (decoded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       br, m2r, mw, rw, put, open, imm;
        logic [3:0] alu;
        logic       ill;
        logic       hlt;
    } exp_t;

    typedef struct {
        exp_t        d;
        logic [7:0]  v;
        logic [11:0] c;
    } item_t;

    item_t       q[$];
    logic        m_halted;
    logic        m_last_valid;
    logic [11:0] m_last;
    logic [11:0] m_count;

    int          n_vec;
    int          n_err;
    logic [11:0] rc;

    localparam logic [8:0] c_w_add  = 9'b000000110;
    localparam logic [8:0] c_w_xor  = 9'b000001010;
    localparam logic [8:0] c_w_halt = 9'b111111110;
    localparam logic [8:0] c_w_ill  = 9'b000100010;
    localparam logic [8:0] c_w_slt  = 9'b000011110;

    // Reference decode, straight from the instruction-set table
    function automatic exp_t ref_decode(input logic [8:0] w);
        exp_t e;
        int   op;
        e      = '0;
        e.alu  = 4'hF;
        e.rw   = 1'b1;
        e.open = 1'b1;
        op     = int'(w[5:1]);
        if (w[0]) begin
            e.put = 1'b1; e.open = 1'b0; e.rw = 1'b0;
        end else begin
            case (op)
                0:  e.imm = 1'b1;
                1:  e.m2r = 1'b1;
                2:  begin e.mw = 1'b1; e.rw = 1'b0; end
                3:  e.alu = 4'd5;
                4:  e.alu = 4'd6;
                5:  e.alu = 4'd1;
                6:  e.alu = 4'd2;
                7:  e.alu = 4'd0;
                12: e.alu = 4'd3;
                13: e.alu = 4'd4;
                14: e.alu = 4'd10;
                8:  begin e.br = 1'b1; e.rw = 1'b0; end
                9:  begin e.alu = 4'd9;  e.rw = 1'b0; end
                10: begin e.alu = 4'd7;  e.rw = 1'b0; end
                11: begin e.alu = 4'd8;  e.rw = 1'b0; end
`ifdef CTRL_SIGNED_CMP_EN
                15: begin e.alu = 4'd11; e.rw = 1'b0; end
                16: begin e.alu = 4'd12; e.rw = 1'b0; end
`endif
                31: begin e.hlt = 1'b1; e.rw = 1'b0; e.open = 1'b0; end
                default: begin e.ill = 1'b1; e.rw = 1'b0; e.open = 1'b0; end
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] dut_flags();
        return {branch_flag, mem_to_reg_flag, mem_write_flag, reg_write_flag,
                put_en, op_en, imm_to_reg_flag, alu_op, illegal};
    endfunction

    task automatic check_model();
        chk("in_ready",  32'(in_ready),  32'(!m_halted && (q.size() < 2)));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("halted",    32'(halted),    32'(m_halted));
        chk("count",     32'(decoded_count), 32'(m_count));
        if (q.size() > 0) begin
            chk("flags", 32'(dut_flags()),
                32'({q[0].d.br, q[0].d.m2r, q[0].d.mw, q[0].d.rw, q[0].d.put,
                     q[0].d.open, q[0].d.imm, q[0].d.alu, q[0].d.ill}));
            chk("value", 32'(value), 32'(q[0].v));
            chk("ctr",   32'(control_ctr), 32'(q[0].c));
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_halted     = 1'b0;
        m_last_valid = 1'b0;
        m_last       = '0;
        m_count      = '0;
    endtask

    // One clock: compare at the falling edge, then advance the model past
    // the rising edge. Returns at posedge+1 with fresh DUT outputs.
    task automatic step();
        logic  acc;
        logic  xfer;
        item_t it;
        @(negedge clk);
        check_model();
        acc  = in_valid && !m_halted && (q.size() < 2);
        xfer = (q.size() > 0) && out_ready;
        @(posedge clk);
        #1;
        if (xfer) begin
            void'(q.pop_front());
            m_count = m_count + 12'd1;
        end
        if (m_halted) begin
            if (resume) begin
                m_halted     = 1'b0;
                m_last_valid = 1'b0;
            end
        end else if (acc && !(m_last_valid && instr_ctr == m_last)) begin
            it.d = ref_decode(instruction);
            it.v = instruction[8:1];
            it.c = instr_ctr;
            q.push_back(it);
            m_last       = instr_ctr;
            m_last_valid = 1'b1;
            if (it.d.hlt) m_halted = 1'b1;
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] w, input logic [11:0] c,
                         input logic ordy, input logic res);
        in_valid    = v;
        instruction = w;
        instr_ctr   = c;
        out_ready   = ordy;
        resume      = res;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_halted"},    32'(halted),    32'd0);
        chk({tag, "_flags"},     32'(dut_flags()), 32'h01E);
        chk({tag, "_value"},     32'(value),     32'd0);
        chk({tag, "_ctr"},       32'(control_ctr), 32'd0);
        chk({tag, "_count"},     32'(decoded_count), 32'd0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = '0;
        instr_ctr   = '0;
        out_ready   = 1'b0;
        resume      = 1'b0;
        model_reset();
        #1;
        check_reset_values("rst0");
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // ADD at counter 1: one-cycle latency
        drive(1'b1, c_w_add, 12'd1, 1'b1, 1'b0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_alu",   32'(alu_op), 32'h5);
        chk("add_rw",    32'(reg_write_flag), 32'd1);
        chk("add_ctr",   32'(control_ctr), 32'd1);
        drive(1'b0, c_w_add, 12'd1, 1'b1, 1'b0);
        chk("add_count", 32'(decoded_count), 32'd1);

        // Duplicate counter filtering: 10, 10, 11 -> two bundles
        drive(1'b1, c_w_add, 12'd10, 1'b1, 1'b0);
        drive(1'b1, c_w_add, 12'd10, 1'b1, 1'b0);
        drive(1'b1, c_w_add, 12'd11, 1'b1, 1'b0);
        drive(1'b0, c_w_add, 12'd11, 1'b1, 1'b0);
        chk("dup_count", 32'(decoded_count), 32'd3);

        // Backpressure: 3, 4 fill output + skid, 5 waits
        drive(1'b1, c_w_xor, 12'd3, 1'b0, 1'b0);
        drive(1'b1, c_w_xor, 12'd4, 1'b0, 1'b0);
        chk("skid_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, c_w_xor, 12'd5, 1'b0, 1'b0);
        chk("hold_ctr", 32'(control_ctr), 32'd3);
        drive(1'b1, c_w_xor, 12'd5, 1'b1, 1'b0);
        chk("drain_ctr4", 32'(control_ctr), 32'd4);
        drive(1'b1, c_w_xor, 12'd5, 1'b1, 1'b0);
        chk("drain_ctr5", 32'(control_ctr), 32'd5);
        drive(1'b0, c_w_xor, 12'd5, 1'b1, 1'b0);
        chk("bp_count", 32'(decoded_count), 32'd6);

        // HALT, blocked input, resume, re-decode of the same counter
        drive(1'b1, c_w_halt, 12'd20, 1'b1, 1'b0);
        chk("halt_rise",  32'(halted), 32'd1);
        chk("halt_ready", 32'(in_ready), 32'd0);
        drive(1'b1, c_w_add, 12'd21, 1'b1, 1'b0);
        drive(1'b0, c_w_add, 12'd21, 1'b1, 1'b1);
        chk("resume_fall",  32'(halted), 32'd0);
        chk("resume_ready", 32'(in_ready), 32'd1);
        drive(1'b1, c_w_halt, 12'd20, 1'b1, 1'b0);
        chk("redecode_ctr", 32'(control_ctr), 32'd20);
        chk("redecode_halt", 32'(halted), 32'd1);
        drive(1'b0, c_w_halt, 12'd20, 1'b1, 1'b1);
        chk("halt_count", 32'(decoded_count), 32'd8);

        // Illegal opcode and the optional signed compare
        drive(1'b1, c_w_ill, 12'd30, 1'b1, 1'b0);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_rw",   32'(reg_write_flag), 32'd0);
        chk("ill_alu",  32'(alu_op), 32'hF);
        drive(1'b1, c_w_slt, 12'd31, 1'b1, 1'b0);
`ifdef CTRL_SIGNED_CMP_EN
        chk("slt_alu", 32'(alu_op), 32'hB);
        chk("slt_ill", 32'(illegal), 32'd0);
`else
        chk("slt_alu", 32'(alu_op), 32'hF);
        chk("slt_ill", 32'(illegal), 32'd1);
`endif
        drive(1'b0, c_w_slt, 12'd31, 1'b1, 1'b0);

        // Randomized traffic
        rc = 12'd100;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) != 0) rc = rc + 12'd1;
            drive(($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 40) == 0) ? c_w_halt : 9'($urandom),
                  rc,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0));
        end

        // Leave HALT and drain, then fill output + skid and reset mid-flight
        for (int i = 0; i < 4; i++) drive(1'b0, c_w_add, rc, 1'b1, 1'b1);
        drive(1'b1, c_w_add, rc + 12'd1, 1'b0, 1'b0);
        drive(1'b1, c_w_xor, rc + 12'd2, 1'b0, 1'b0);
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check_reset_values("arst");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b0, c_w_add, rc + 12'd2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_control_pipe
`default_nettype wire
